// File: rtl/ifu_fetch.sv
// ifu_fetch -- single-outstanding instruction fetch unit.
//
// Issues one instruction-memory read at a time from the PC, then registers the
// returned word into a decode-facing output stage. When decode stalls, the word
// goes into a 1-entry buffer. Execute redirects override everything else:
// in-flight data is killed, the buffer is dropped, and the output becomes a bubble.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   jump_en_i/jump_addr_i redirect request and target (word aligned internally)
//   hold_i                downstream stall, freezes the output stage
//   mem_req_o/mem_addr_o  read request and address (address = PC)
//   mem_gnt_i             request accepted this cycle
//   mem_rvalid_i/rdata_i  read response
//   inst_o/inst_addr_o/inst_valid_o  registered output stage to decode
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        valid;
  } stage_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fa_q, fa_d;
  logic        kill_q, kill_d;
  stage_t      buf_q, buf_d;   // valid field unused: FULL state implies occupancy
  stage_t      out_q, out_d;

  // rst_n gate keeps the request low while reset is held even though state=REQ.
  assign mem_req_o    = rst_n & (state_q == S_REQ) & ~jump_en_i;
  assign mem_addr_o   = pc_q;
  assign inst_o       = out_q.inst;
  assign inst_addr_o  = out_q.addr;
  assign inst_valid_o = out_q.valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fa_d    = fa_q;
    kill_d  = kill_q;
    buf_d   = buf_q;
    out_d   = out_q;

    // Unstalled and nothing loaded this edge: present a bubble, keep the address.
    if (!hold_i) begin
      out_d.inst  = NOP_INST;
      out_d.valid = 1'b0;
    end

    if (jump_en_i) begin
      // Redirect wins over hold and over a same-cycle response.
      pc_d        = jump_addr_i & ~32'h3;
      out_d.inst  = NOP_INST;
      out_d.valid = 1'b0;
      buf_d       = '0;
      unique case (state_q)
        S_WAIT: begin
          if (mem_rvalid_i) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d  = 1'b1;     // response still owed; drop it when it arrives
          end
        end
        S_FULL:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (mem_gnt_i) begin
            fa_d    = pc_q;
            pc_d    = pc_q + 32'd4;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (!hold_i) begin
              out_d   = '{inst: mem_rdata_i, addr: fa_q, valid: 1'b1};
              state_d = S_REQ;
            end else begin
              buf_d   = '{inst: mem_rdata_i, addr: fa_q, valid: 1'b1};
              state_d = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!hold_i) begin
            out_d   = '{inst: buf_q.inst, addr: buf_q.addr, valid: 1'b1};
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      fa_q    <= '0;
      kill_q  <= 1'b0;
      buf_q   <= '0;
      out_q   <= '{inst: NOP_INST, addr: 32'h0, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fa_q    <= fa_d;
      kill_q  <= kill_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, basic fetch, stall/buffer, redirect
// kill, redirect vs hold+rvalid, PC wrap, async reset mid-transaction.
module tb_ifu_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        jump_en, hold, gnt, rvalid;
  logic [31:0] jump_addr, rdata;
  logic        mem_req;
  logic [31:0] mem_addr, inst, inst_addr;
  logic        inst_valid;

  int checks = 0;
  int errors = 0;

  ifu_fetch #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en), .jump_addr_i(jump_addr), .hold_i(hold),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .inst_o(inst), .inst_addr_o(inst_addr), .inst_valid_o(inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] i, input logic [31:0] a, input logic v);
    check({tag, ".inst"}, inst, i);
    check({tag, ".addr"}, inst_addr, a);
    check({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, v});
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    check({tag, ".req"}, {31'h0, mem_req}, {31'h0, r});
    if (r) check({tag, ".maddr"}, mem_addr, a);
  endtask

  initial begin
    jump_en = 0; jump_addr = 0; hold = 0; gnt = 0; rvalid = 0; rdata = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_out("reset", NOP, 32'h0, 1'b0);
    check("reset.req", {31'h0, mem_req}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    #1 chk_req("release", 1'b1, 32'h0);

    // Basic fetch: grant, rvalid next cycle, data two cycles after grant.
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 32'h0010_0093;
    #1 chk_req("wait", 1'b0, 32'h0);
    tick();
    rvalid = 0;
    chk_out("first", 32'h0010_0093, 32'h0, 1'b1);
    chk_req("first", 1'b1, 32'h4);

    // Second fetch; bubble while waiting.
    gnt = 1;
    tick();
    gnt = 0;
    chk_out("bubble", NOP, 32'h0, 1'b0);
    rvalid = 1; rdata = 32'hAAAA_0001;
    tick();
    rvalid = 0;
    chk_out("second", 32'hAAAA_0001, 32'h4, 1'b1);
    chk_req("second", 1'b1, 32'h8);

    // Stall: rvalid at addr 8 under hold goes to the buffer.
    gnt = 1; hold = 1;
    tick();
    gnt = 0;
    chk_out("holdwait", 32'hAAAA_0001, 32'h4, 1'b1);
    rvalid = 1; rdata = 32'hBBBB_0002;
    tick();
    rvalid = 1; rdata = 32'hDEAD_BEEF;   // response in FULL must be ignored
    chk_out("full", 32'hAAAA_0001, 32'h4, 1'b1);
    chk_req("full", 1'b0, 32'h0);
    tick();
    rvalid = 0;
    chk_req("full2", 1'b0, 32'h0);
    hold = 0;
    tick();
    chk_out("drain", 32'hBBBB_0002, 32'h8, 1'b1);
    chk_req("drain", 1'b1, 32'hC);

    // Redirect while waiting; the late response is killed.
    gnt = 1;
    tick();
    gnt = 0; jump_en = 1; jump_addr = 32'h0000_0103;
    #1 chk_req("jmpreq", 1'b0, 32'h0);
    tick();
    jump_en = 0;
    tick();
    rvalid = 1; rdata = 32'hCCCC_CCCC;
    tick();
    rvalid = 0;
    chk_out("killed", NOP, 32'h8, 1'b0);
    chk_req("killed", 1'b1, 32'h100);

    // Load one at 0x100, then redirect coincident with rvalid and hold.
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 32'h1111_1111;
    tick();
    rvalid = 0;
    chk_out("at100", 32'h1111_1111, 32'h100, 1'b1);
    gnt = 1; hold = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 32'hEEEE_EEEE; jump_en = 1; jump_addr = 32'h0000_0200;
    tick();
    rvalid = 0; jump_en = 0; hold = 0;
    #1;
    chk_out("jmphold", NOP, 32'h100, 1'b0);
    chk_req("jmphold", 1'b1, 32'h200);

    // PC wrap at the top of the address space.
    jump_en = 1; jump_addr = 32'hFFFF_FFFE;
    tick();
    jump_en = 0;
    #1 chk_req("top", 1'b1, 32'hFFFF_FFFC);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 32'h2222_2222;
    tick();
    rvalid = 0;
    chk_out("top", 32'h2222_2222, 32'hFFFF_FFFC, 1'b1);
    chk_req("wrap", 1'b1, 32'h0);

    // Async reset in WAIT with a valid instruction held at the output.
    gnt = 1; hold = 1;
    tick();
    gnt = 0;
    chk_out("prerst", 32'h2222_2222, 32'hFFFF_FFFC, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("asyncrst", NOP, 32'h0, 1'b0);
    check("asyncrst.req", {31'h0, mem_req}, 32'h0);
    hold = 0;
    tick();
    #1 rst_n = 1'b1;
    #1 chk_req("restart", 1'b1, 32'h0);
    rvalid = 1; rdata = 32'h3333_3333;   // stale response from before reset
    tick();
    rvalid = 0;
    chk_out("stale", NOP, 32'h0, 1'b0);
    chk_req("stale", 1'b1, 32'h0);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 32'h4444_4444;
    tick();
    rvalid = 0;
    chk_out("refetch", 32'h4444_4444, 32'h0, 1'b1);
    chk_req("refetch", 1'b1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), the instruction presented when no valid instruction is held.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 jump_en_i  in  1  redirect request from execute.
REQ-007 jump_addr_i  in  32  redirect target.
REQ-008 hold_i  in  1  downstream stall; output stage must not change.
REQ-009 mem_req_o  out  1  instruction-memory read request.
REQ-010 mem_addr_o  out  32  read address, valid while mem_req_o=1.
REQ-011 mem_gnt_i  in  1  memory accepts the request this cycle.
REQ-012 mem_rvalid_i  in  1  read data valid this cycle.
REQ-013 mem_rdata_i  in  32  read data.
REQ-014 inst_o  out  32  instruction to decode stage (registered).
REQ-015 inst_addr_o  out  32  address of inst_o (registered).
REQ-016 inst_valid_o  out  1  inst_o is a real fetched instruction (registered).

Function
REQ-017 The block SHALL hold a PC register pc_q, a fetch-address register fa_q, a 1-entry buffer (buf_inst, buf_addr) and a kill flag.
REQ-018 The FSM SHALL have states REQ, WAIT, FULL; at most one memory read outstanding.
REQ-019 mem_req_o SHALL equal (state==REQ) & ~jump_en_i; mem_addr_o SHALL equal pc_q.
REQ-020 REQ: on mem_req_o & mem_gnt_i -> fa_q<=pc_q, pc_q<=pc_q+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go WAIT.
REQ-021 WAIT, mem_rvalid_i=1, kill=0, jump_en_i=0, hold_i=0 -> inst_o<=mem_rdata_i, inst_addr_o<=fa_q, inst_valid_o<=1, go REQ.
REQ-022 WAIT, mem_rvalid_i=1, kill=0, jump_en_i=0, hold_i=1 -> buf<=(mem_rdata_i, fa_q), output stage unchanged, go FULL.
REQ-023 WAIT, mem_rvalid_i=1 with kill=1 or jump_en_i=1 -> data discarded, kill<=0, go REQ.
REQ-024 WAIT, mem_rvalid_i=0, jump_en_i=1 -> kill<=1, stay WAIT.
REQ-025 FULL: no request issued; on hold_i=0 -> output stage<=buf with inst_valid_o<=1, go REQ.
REQ-026 When no load occurs and hold_i=0, and state is not FULL, inst_valid_o SHALL go 0 and inst_o SHALL be NOP_INST (inst_addr_o holds).
REQ-027 hold_i=1 SHALL freeze inst_o, inst_addr_o, inst_valid_o, except as overridden by REQ-028.
REQ-028 jump_en_i=1 in any state SHALL, at that edge: pc_q<={jump_addr_i[31:2],2'b00}; inst_o<=NOP_INST; inst_valid_o<=0; buffer discarded; FULL->REQ; priority over hold_i and over any same-cycle rvalid.
REQ-029 mem_rvalid_i in REQ or FULL SHALL be ignored.
REQ-030 Latency: grant cycle N, rvalid cycle N+k (k>=1) -> inst_o valid from cycle N+k+1; zero-wait memory gives one instruction per 2 cycles.
REQ-031 Every instruction with kill=0 and no jump SHALL reach inst_o exactly once, in address order.

Reset
REQ-032 While rst_n=0: pc_q=RESET_PC, fa_q=0, state=REQ, kill=0, buffer cleared, inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0, mem_req_o=0.
REQ-033 Reset assertion mid-transaction SHALL abandon the outstanding read; a late rvalid after release, while in REQ, is ignored per REQ-029.
REQ-034 First cycle after release: mem_req_o=1, mem_addr_o=RESET_PC.

Verification
REQ-035 Reset release, gnt immediate, rvalid next cycle, rdata=32'h0010_0093 -> inst_o=32'h0010_0093, inst_addr_o=0, inst_valid_o=1 two cycles after grant; next mem_addr_o=4.
REQ-036 hold_i=1 while rvalid at addr 8 -> outputs frozen, state FULL, mem_req_o=0; hold_i=0 -> inst_addr_o=8 next edge, then request to 12.
REQ-037 jump_en_i=1, jump_addr_i=32'h0000_0103 in WAIT, rvalid two cycles later -> that data discarded, inst_valid_o=0, next mem_addr_o=32'h0000_0100.
REQ-038 jump_en_i coincident with rvalid and hold_i=1 -> inst_o=NOP_INST, inst_valid_o=0, mem_addr_o=jump target next cycle.
REQ-039 pc_q=32'hFFFF_FFFC granted -> next mem_addr_o=0.
REQ-040 rst_n=0 asserted asynchronously in WAIT -> all outputs at REQ-032 values immediately; after release fetch restarts at RESET_PC.
